// File: rtl/irq_defs.sv
// irq_defs: shared sizes and FSM state encodings for the 8-source interrupt arbiter.
package irq_defs;
  localparam int N_SRC = 8;
  localparam int ID_W = 3;
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_PRESENT    = 2'd1,
    ST_IN_SERVICE = 2'd2
  } state_t;
endpackage

// File: rtl/priority_encoder_8to3.sv
// priority_encoder_8to3: returns the highest set index of d, v flags any bit set.
module priority_encoder_8to3
  import irq_defs::*;
(
  input  logic [N_SRC-1:0] d,
  output logic [ID_W-1:0]  y,
  output logic             v
);
  always_comb begin
    y = '0;
    for (int i = 0; i < N_SRC; i++) y = d[i] ? ID_W'(i) : y;
  end
  assign v = |d;
endmodule

// File: rtl/irq_arbiter_8.sv
// irq_arbiter_8: synchronises 8 IRQ lines, latches them as pending and presents the
// highest-index enabled one to the CPU over valid/ready, tracking it until eoi.
module irq_arbiter_8
  import irq_defs::*;
#(
  parameter int               SYNC_STAGES = 2,
  parameter logic [N_SRC-1:0] EDGE_MASK   = 8'hFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_in,
  input  logic [N_SRC-1:0] mask,
  output logic             irq_valid,
  input  logic             irq_ready,
  output logic [ID_W-1:0]  irq_id,
  input  logic             eoi,
  output logic             busy,
  output logic [N_SRC-1:0] pending
);
  logic [N_SRC-1:0] s, s_prev, set_bits, clr_bits, req;
  logic [ID_W-1:0]  enc_id, id_n;
  logic             enc_v, accept;
  state_t           state, state_n;
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = irq_in;
    end else begin : g_sync
      logic [N_SRC-1:0] q [SYNC_STAGES];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < SYNC_STAGES; i++) q[i] <= '0;
        end else begin
          q[0] <= irq_in;
          for (int i = 1; i < SYNC_STAGES; i++) q[i] <= q[i-1];
        end
      end
      assign s = q[SYNC_STAGES-1];
    end
  endgenerate
  assign set_bits = (s & ~s_prev & EDGE_MASK) | (s & ~EDGE_MASK);
  assign accept   = (state == ST_PRESENT) & irq_ready;
  assign clr_bits = accept ? N_SRC'(1) << irq_id : '0;
  assign req      = pending & mask;
  priority_encoder_8to3 u_enc (
    .d(req),
    .y(enc_id),
    .v(enc_v)
  );
  always_comb begin
    state_n = state;
    id_n    = irq_id;
    case (state)
      ST_IDLE: begin
        state_n = enc_v ? ST_PRESENT : ST_IDLE;
        id_n    = enc_v ? enc_id : irq_id;
      end
      ST_PRESENT:    state_n = irq_ready ? ST_IN_SERVICE : ST_PRESENT;
      ST_IN_SERVICE: state_n = eoi ? ST_IDLE : ST_IN_SERVICE;
      default:       state_n = ST_IDLE;
    endcase
  end
  // set wins over the accept-cycle clear, so a still-high level source stays pending
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_prev    <= '0;
      pending   <= '0;
      state     <= ST_IDLE;
      irq_id    <= '0;
      irq_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      s_prev    <= s;
      pending   <= (pending & ~clr_bits) | set_bits;
      state     <= state_n;
      irq_id    <= id_n;
      irq_valid <= state_n == ST_PRESENT;
      busy      <= state_n == ST_IN_SERVICE;
    end
  end
endmodule
